// File: rtl/nibble_divider_pkg.sv
// Shared definitions for the nibble-serial restoring divider: FSM state
// encoding, default divisor width and step-counter sizing.
package nibble_divider_pkg;

    // Default divisor width; dividend and quotient are twice this.
    localparam int NIB_N_DEFAULT = 4;

    // Step counter must be able to count the 2N division steps.
    function automatic int step_cnt_w(input int n);
        return $clog2(2 * n + 1);
    endfunction

    localparam int STEP_CNT_W_DEFAULT = step_cnt_w(NIB_N_DEFAULT);

    typedef enum logic [2:0] {
        LOAD_HI  = 3'd0,
        LOAD_LO  = 3'd1,
        LOAD_DIV = 3'd2,
        DIVIDE   = 3'd3,
        DONE     = 3'd4
    } state_e;

endpackage

// File: rtl/nibble_divider_div_step.sv
// One combinational restoring-division step: shift the next dividend bit
// into the partial remainder, trial-subtract the divisor, keep the
// difference only when it does not go negative.
module div_step #(
    parameter int N = 4
) (
    input  logic [N-1:0] rem_i,
    input  logic         msb_i,
    input  logic [N-1:0] divisor_i,
    output logic [N-1:0] rem_o,
    output logic         qbit_o
);

    // The stored remainder is always below the divisor, so N bits hold it;
    // the shifted trial value needs the extra bit before the subtraction.
    logic [N:0] trial;

    // Shift, compare and conditionally subtract.
    always_comb begin
        trial  = {rem_i, msb_i};
        qbit_o = (trial >= {1'b0, divisor_i});
        rem_o  = qbit_o ? N'(trial - {1'b0, divisor_i}) : trial[N-1:0];
    end

endmodule

// File: rtl/nibble_divider.sv
// Nibble-serial unsigned divider: loads dividend high, dividend low and
// divisor nibbles, then produces one quotient bit per clock.
// Optional macro NIBBLE_DIVIDER_DIV_ZERO_EN short-cuts a zero divisor straight
// to the result with q = all ones, r = 0 and div_by_zero flagged.
module nibble_divider
    import nibble_divider_pkg::*;
#(
    parameter int N = NIB_N_DEFAULT
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           nib_valid,
    input  logic [N-1:0]   nib,
    output logic           busy,
    output logic           done,
    output logic [2*N-1:0] q,
    output logic [N-1:0]   r,
    output logic           div_by_zero
);

    localparam int CNT_W = step_cnt_w(N);
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(2 * N - 1);

    state_e           state_q, state_d;
    logic [2*N-1:0]   dvd_q;      // dividend, becomes the quotient as it shifts
    logic [N-1:0]     dvs_q;
    logic [N-1:0]     rem_q;
    logic [N-1:0]     rem_nxt;
    logic             qbit;
    logic [CNT_W-1:0] cnt_q;
    logic [2*N-1:0]   q_q;
    logic [N-1:0]     r_q;
    logic             last_step;

    assign last_step = (cnt_q == LAST_STEP);

    div_step #(.N(N)) u_step (
        .rem_i     (rem_q),
        .msb_i     (dvd_q[2*N-1]),
        .divisor_i (dvs_q),
        .rem_o     (rem_nxt),
        .qbit_o    (qbit)
    );

`ifdef NIBBLE_DIVIDER_DIV_ZERO_EN
    logic div_zero;
    logic dz_q;
    assign div_zero    = (nib == '0);
    assign div_by_zero = dz_q;
`else
    assign div_by_zero = 1'b0;
`endif

    assign q = q_q;
    assign r = r_q;

    // FSM state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= LOAD_HI;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic; load states wait for nib_valid.
    always_comb begin
        state_d = state_q;
        case (state_q)
            LOAD_HI:  if (nib_valid) state_d = LOAD_LO;
            LOAD_LO:  if (nib_valid) state_d = LOAD_DIV;
            LOAD_DIV: begin
                if (nib_valid) begin
`ifdef NIBBLE_DIVIDER_DIV_ZERO_EN
                    state_d = div_zero ? DONE : DIVIDE;
`else
                    state_d = DIVIDE;
`endif
                end
            end
            DIVIDE:   if (last_step) state_d = DONE;
            DONE:     state_d = LOAD_HI;
            default:  state_d = LOAD_HI;
        endcase
    end

    // FSM outputs decoded from the current state.
    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        case (state_q)
            DIVIDE:  busy = 1'b1;
            DONE: begin
                busy = 1'b1;
                done = 1'b1;
            end
            default: ;
        endcase
    end

    // Operand capture and per-step shifting; no reset needed on pure data.
    always_ff @(posedge clk) begin
        case (state_q)
            LOAD_HI:  if (nib_valid) dvd_q[2*N-1:N] <= nib;
            LOAD_LO:  if (nib_valid) dvd_q[N-1:0]   <= nib;
            LOAD_DIV: begin
                if (nib_valid) begin
                    dvs_q <= nib;
                    rem_q <= '0;
                end
            end
            DIVIDE: begin
                dvd_q <= {dvd_q[2*N-2:0], qbit};
                rem_q <= rem_nxt;
            end
            default: ;
        endcase
    end

    // Step counter: cleared when the divisor lands, advances each step.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else if (state_q == LOAD_DIV && nib_valid) begin
            cnt_q <= '0;
        end else if (state_q == DIVIDE) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    // Result registers, written only on the edge that enters DONE.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q_q <= '0;
            r_q <= '0;
`ifdef NIBBLE_DIVIDER_DIV_ZERO_EN
            dz_q <= 1'b0;
`endif
        end else begin
            if (state_q == DIVIDE && last_step) begin
                q_q <= {dvd_q[2*N-2:0], qbit};
                r_q <= rem_nxt;
`ifdef NIBBLE_DIVIDER_DIV_ZERO_EN
                dz_q <= 1'b0;
`endif
            end
`ifdef NIBBLE_DIVIDER_DIV_ZERO_EN
            if (state_q == LOAD_DIV && nib_valid && div_zero) begin
                q_q  <= '1;
                r_q  <= '0;
                dz_q <= 1'b1;
            end
`endif
        end
    end

endmodule

// File: tb/tb_nibble_divider.sv
// Directed self-checking bench for nibble_divider (N = 4).
module tb_nibble_divider;

    logic       clk;
    logic       rst;
    logic       nib_valid;
    logic [3:0] nib;
    logic       busy;
    logic       done;
    logic [7:0] q;
    logic [3:0] r;
    logic       div_by_zero;

    int pass_cnt;
    int total_cnt;

    nibble_divider #(.N(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .nib_valid   (nib_valid),
        .nib         (nib),
        .busy        (busy),
        .done        (done),
        .q           (q),
        .r           (r),
        .div_by_zero (div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Present one nibble once the divider is idle; returns 1ns after the
    // consuming edge with nib_valid dropped again.
    task automatic send(input logic [3:0] v, input int gap);
        int k;
        repeat (gap) @(posedge clk);
        @(negedge clk);
        k = 0;
        while (busy && k < 40) begin
            @(negedge clk);
            k++;
        end
        nib_valid = 1'b1;
        nib       = v;
        @(posedge clk);
        #1;
        nib_valid = 1'b0;
        nib       = 4'h0;
    endtask

    // Count edges from the divisor edge until done is seen (bounded).
    task automatic wait_done(output int edges);
        edges = 0;
        while (!done && edges < 20) begin
            @(posedge clk);
            #1;
            edges++;
        end
    endtask

    task automatic run_op(input string name,
                          input logic [3:0] a, input logic [3:0] b, input logic [3:0] c,
                          input int ga, input int gb, input int gc,
                          input int exp_edges,
                          input logic [7:0] eq, input logic [3:0] er, input logic edz);
        int edges;
        send(a, ga);
        send(b, gb);
        send(c, gc);
        total_cnt++;
        if (busy !== 1'b1) $display("FAIL %s busy_after_div got=%b exp=1", name, busy);
        else pass_cnt++;
        wait_done(edges);
        total_cnt++;
        if (edges !== exp_edges) $display("FAIL %s latency got=%0d exp=%0d", name, edges, exp_edges);
        else pass_cnt++;
        total_cnt++;
        if (q !== eq) $display("FAIL %s q got=%h exp=%h", name, q, eq);
        else pass_cnt++;
        total_cnt++;
        if (r !== er) $display("FAIL %s r got=%h exp=%h", name, r, er);
        else pass_cnt++;
        total_cnt++;
        if (div_by_zero !== edz) $display("FAIL %s dz got=%b exp=%b", name, div_by_zero, edz);
        else pass_cnt++;
    endtask

    task automatic check_idle_outputs(input string name);
        total_cnt++;
        if (busy !== 1'b0) $display("FAIL %s busy got=%b exp=0", name, busy);
        else pass_cnt++;
        total_cnt++;
        if (done !== 1'b0) $display("FAIL %s done got=%b exp=0", name, done);
        else pass_cnt++;
        total_cnt++;
        if (q !== 8'h00) $display("FAIL %s q got=%h exp=00", name, q);
        else pass_cnt++;
        total_cnt++;
        if (r !== 4'h0) $display("FAIL %s r got=%h exp=0", name, r);
        else pass_cnt++;
        total_cnt++;
        if (div_by_zero !== 1'b0) $display("FAIL %s dz got=%b exp=0", name, div_by_zero);
        else pass_cnt++;
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        nib_valid = 1'b0;
        nib       = 4'h0;
        #1 rst = 1'b0;
        #2;
        check_idle_outputs("reset");
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_basic();
        run_op("div200_7", 4'hC, 4'h8, 4'h7, 0, 0, 0, 8, 8'h1C, 4'h4, 1'b0);
        // One edge later done has dropped, busy has dropped, result is held.
        @(posedge clk);
        #1;
        total_cnt++;
        if (done !== 1'b0 || busy !== 1'b0)
            $display("FAIL after_done done=%b busy=%b exp 0/0", done, busy);
        else pass_cnt++;
        total_cnt++;
        if (q !== 8'h1C) $display("FAIL held_q got=%h exp=1c", q);
        else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        run_op("div255_15", 4'hF, 4'hF, 4'hF, 0, 0, 0, 8, 8'h11, 4'h0, 1'b0);
        run_op("div5_9",    4'h0, 4'h5, 4'h9, 0, 0, 0, 8, 8'h00, 4'h5, 1'b0);
    endtask

    task automatic test_div_zero();
`ifdef NIBBLE_DIVIDER_DIV_ZERO_EN
        run_op("div_zero", 4'h3, 4'hC, 4'h0, 0, 0, 0, 0, 8'hFF, 4'h0, 1'b1);
        run_op("after_zero", 4'h0, 4'h9, 4'h3, 0, 0, 0, 8, 8'h03, 4'h0, 1'b0);
`else
        run_op("div_zero", 4'h3, 4'hC, 4'h0, 0, 0, 0, 8, 8'hFF, 4'hC, 1'b0);
`endif
    endtask

    task automatic test_ignore_busy();
        int edges;
        send(4'hC, 0);
        send(4'h8, 0);
        send(4'h7, 0);
        edges = 0;
        while (!done && edges < 20) begin
            @(negedge clk);
            nib_valid = edges[0];
            nib       = 4'(edges + 3);
            @(posedge clk);
            #1;
            edges++;
        end
        nib_valid = 1'b0;
        nib       = 4'h0;
        total_cnt++;
        if (edges !== 8) $display("FAIL junk_latency got=%0d exp=8", edges);
        else pass_cnt++;
        total_cnt++;
        if (q !== 8'h1C || r !== 4'h4)
            $display("FAIL junk_result got=%h/%h exp=1c/4", q, r);
        else pass_cnt++;
        run_op("div100_3", 4'h6, 4'h4, 4'h3, 0, 0, 0, 8, 8'h21, 4'h1, 1'b0);
    endtask

    task automatic test_reset_mid();
        send(4'hC, 0);
        send(4'h8, 0);
        send(4'h7, 0);
        repeat (4) @(posedge clk);
        #2 rst = 1'b0;
        #1;
        check_idle_outputs("reset_mid");
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        run_op("div16_4", 4'h1, 4'h0, 4'h4, 0, 0, 0, 8, 8'h04, 4'h0, 1'b0);
    endtask

    task automatic test_gaps();
        for (int g = 1; g <= 5; g += 2) begin
            run_op($sformatf("gap%0d", g), 4'hC, 4'h8, 4'h7,
                   g, (g + 2) % 6, 5 - g, 8, 8'h1C, 4'h4, 1'b0);
        end
    endtask

    initial begin
        pass_cnt  = 0;
        total_cnt = 0;
        test_reset();
        test_basic();
        test_back_to_back();
        test_div_zero();
        test_ignore_busy();
        test_reset_mid();
        test_gaps();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
